// File: rtl/hd_link_pkg.sv
// rtl/hd_link_pkg.sv - shared types for the half-duplex link arbiter family
package hd_link_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } hd_arb_state_e;

  typedef logic port_idx_t;

  localparam int MaxTurnaround = 15;

endpackage

// File: rtl/hd_burst_counter.sv
// rtl/hd_burst_counter.sv - per-grant beat counter with last/max-burst release detect
module hd_burst_counter #(
  parameter int MaxBurst = 16,
  parameter int CntWidth = $clog2(MaxBurst + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic beat_i,
  input  logic last_i,
  output logic release_o
);

  logic [CntWidth-1:0] beat_cnt;
  logic [CntWidth:0]   cnt_next;
  logic                at_max;

  // One extra bit so the compare against MaxBurst never aliases on a full counter.
  assign cnt_next  = {1'b0, beat_cnt} + 1'b1;
  assign at_max    = (cnt_next == (CntWidth + 1)'(MaxBurst));
  assign release_o = beat_i & (last_i | at_max);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      beat_cnt <= '0;
    end else if (beat_i) begin
      beat_cnt <= cnt_next[CntWidth-1:0];
    end
  end

endmodule

// File: rtl/half_duplex_link_arbiter.sv
// rtl/half_duplex_link_arbiter.sv - direction sequencer for a shared two-port half-duplex bus
module half_duplex_link_arbiter
  import hd_link_pkg::*;
#(
  parameter int TurnaroundCycles = 2,
  parameter int MaxBurst         = 16,
  parameter int CntWidth         = $clog2(MaxBurst + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] tx_mode_o,
  output logic [1:0] beat_o,
  output logic [1:0] rx_valid_o,
  output logic       turnaround_o,
  output logic       busy_o
);

  localparam int         TaClamped = (TurnaroundCycles > MaxTurnaround) ? MaxTurnaround
                                                                        : TurnaroundCycles;
  localparam logic [3:0] TaLast    = 4'(TaClamped - 1);

  hd_arb_state_e state;
  port_idx_t     owner;
  port_idx_t     rr_ptr;
  port_idx_t     pick;
  logic [3:0]    ta_cnt;
  logic          owner_req;
  logic          owner_last;
  logic          owner_beat;
  logic          burst_release;
  logic          grant_exit;

  assign owner_req  = req_i[owner];
  assign owner_last = last_i[owner];
  assign owner_beat = (state == GRANT) && owner_req;
  // A withdrawn request releases the bus without a beat.
  assign grant_exit = (state == GRANT) && (!owner_req || burst_release);
  assign pick       = (req_i == 2'b11) ? rr_ptr : port_idx_t'(req_i[1]);

  assign beat_o       = tx_mode_o & req_i;
  assign rx_valid_o   = {beat_o[0], beat_o[1]};
  assign turnaround_o = (state == TURNAROUND);
  assign busy_o       = (state != IDLE);

  hd_burst_counter #(
    .MaxBurst (MaxBurst),
    .CntWidth (CntWidth)
  ) u_burst_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (grant_exit),
    .beat_i    (owner_beat),
    .last_i    (owner_last),
    .release_o (burst_release)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      ta_cnt    <= '0;
      tx_mode_o <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_i != 2'b00) begin
            state     <= GRANT;
            owner     <= pick;
            tx_mode_o <= pick ? 2'b10 : 2'b01;
          end
        end
        GRANT: begin
          if (grant_exit) begin
            state     <= TURNAROUND;
            rr_ptr    <= ~owner;
            ta_cnt    <= '0;
            tx_mode_o <= 2'b00;
          end
        end
        TURNAROUND: begin
          if (ta_cnt == TaLast) begin
            state  <= IDLE;
            ta_cnt <= '0;
          end else begin
            ta_cnt <= ta_cnt + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          tx_mode_o <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (tx_mode_o != 2'b11);
    end
  end

endmodule

// File: tb/tb_half_duplex_link_arbiter.sv
// tb/tb_half_duplex_link_arbiter.sv - self-checking bench with a behavioural bus-ownership model
module tb_half_duplex_link_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] req_a = '0, last_a = '0, req_b = '0, last_b = '0;
  logic [1:0] tx_a, beat_a, rx_a, tx_b, beat_b, rx_b;
  logic       ta_a, busy_a, ta_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  half_duplex_link_arbiter dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .last_i(last_a),
    .tx_mode_o(tx_a), .beat_o(beat_a), .rx_valid_o(rx_a),
    .turnaround_o(ta_a), .busy_o(busy_a)
  );

  half_duplex_link_arbiter #(.TurnaroundCycles(1), .MaxBurst(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .last_i(last_b),
    .tx_mode_o(tx_b), .beat_o(beat_b), .rx_valid_o(rx_b),
    .turnaround_o(ta_b), .busy_o(busy_b)
  );

  // Model: current owner (-1 = nobody), remaining gap cycles, beats in this grant, preferred port.
  int m_owner[2] = '{-1, -1};
  int m_gap[2]   = '{0, 0};
  int m_beats[2] = '{0, 0};
  int m_pref[2]  = '{0, 0};
  int p_ta[2]    = '{2, 1};
  int p_mb[2]    = '{16, 1};

  function automatic logic [1:0] exp_tx(int k);
    if (m_owner[k] < 0) return 2'b00;
    return (m_owner[k] == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic exp_ta(int k);
    return m_gap[k] > 0;
  endfunction

  function automatic logic exp_busy(int k);
    return (m_owner[k] >= 0) || (m_gap[k] > 0);
  endfunction

  function automatic void model_step(int k, logic [1:0] rq, logic [1:0] ls);
    int  o;
    bit  rel;
    if (rst) begin
      m_owner[k] = -1; m_gap[k] = 0; m_beats[k] = 0; m_pref[k] = 0;
    end else if (m_owner[k] >= 0) begin
      o = m_owner[k];
      rel = 1'b1;
      if (rq[o]) begin
        m_beats[k] = m_beats[k] + 1;
        rel = ls[o] || (m_beats[k] == p_mb[k]);
      end
      if (rel) begin
        m_pref[k] = 1 - o; m_owner[k] = -1; m_beats[k] = 0; m_gap[k] = p_ta[k];
      end
    end else if (m_gap[k] > 0) begin
      m_gap[k] = m_gap[k] - 1;
    end else if (rq == 2'b01) begin
      m_owner[k] = 0;
    end else if (rq == 2'b10) begin
      m_owner[k] = 1;
    end else if (rq == 2'b11) begin
      m_owner[k] = m_pref[k];
    end
  endfunction

  task automatic advance();
    model_step(0, req_a, last_a);
    model_step(1, req_b, last_b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = '0; last_a = '0; req_b = '0; last_b = '0;
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 2'b11; req_b = 2'b11; last_a = 2'b11; last_b = 2'b11;
    advance();
    @(negedge clk);
    n_checks += 4;
    if (tx_a !== 2'b00)   begin n_fail++; $display("FAIL reset_tx_a: got %b want 00", tx_a); end
    if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    if (ta_a !== 1'b0)    begin n_fail++; $display("FAIL reset_ta_a: got %b want 0", ta_a); end
    if (tx_b !== 2'b00)   begin n_fail++; $display("FAIL reset_tx_b: got %b want 00", tx_b); end
    advance();
    rst = 1'b0; req_a = '0; req_b = '0; last_a = '0; last_b = '0;
    @(negedge clk);
    n_checks += 3;
    if (beat_a !== 2'b00) begin n_fail++; $display("FAIL reset_beat_a: got %b want 00", beat_a); end
    if (rx_a !== 2'b00)   begin n_fail++; $display("FAIL reset_rx_a: got %b want 00", rx_a); end
    if (busy_b !== 1'b0)  begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    advance();
  endtask

  task automatic test_single_port();
    logic [8:1] want_tx   = 8'b00011110;
    logic [8:1] want_ta   = 8'b01100000;
    logic [8:1] want_busy = 8'b01111110;
    int nbeat = 0, nrx = 0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      req_a  = 2'b01;
      last_a = (c == 5) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_checks += 3;
      if (tx_a !== {1'b0, want_tx[c]}) begin n_fail++; $display("FAIL single_tx c%0d: got %b want 0%b", c, tx_a, want_tx[c]); end
      if (ta_a !== want_ta[c])         begin n_fail++; $display("FAIL single_ta c%0d: got %b want %b", c, ta_a, want_ta[c]); end
      if (busy_a !== want_busy[c])     begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", c, busy_a, want_busy[c]); end
      if (beat_a[0]) nbeat++;
      if (rx_a[1])   nrx++;
      advance();
    end
    n_checks += 2;
    if (nbeat != 4) begin n_fail++; $display("FAIL single_beats: got %0d want 4", nbeat); end
    if (nrx != 4)   begin n_fail++; $display("FAIL single_rx: got %0d want 4", nrx); end
  endtask

  task automatic test_simultaneous();
    int n01 = 0, n10 = 0, nta = 0, n11 = 0, first10 = 0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      req_a = 2'b11; last_a = 2'b00;
      @(negedge clk);
      n_checks++;
      if (tx_a !== exp_tx(0)) begin n_fail++; $display("FAIL simul_model c%0d: got %b want %b", c, tx_a, exp_tx(0)); end
      if (c < 40) begin
        if (tx_a == 2'b01) n01++;
        if (tx_a == 2'b10) begin n10++; if (first10 == 0) first10 = c; end
        if (tx_a == 2'b11) n11++;
        if (ta_a) nta++;
      end else begin
        n_checks++;
        if (tx_a !== 2'b01) begin n_fail++; $display("FAIL simul_regrant: got %b want 01", tx_a); end
      end
      advance();
    end
    n_checks += 5;
    if (n01 != 16)     begin n_fail++; $display("FAIL simul_port1_len: got %0d want 16", n01); end
    if (n10 != 16)     begin n_fail++; $display("FAIL simul_port2_len: got %0d want 16", n10); end
    if (nta != 4)      begin n_fail++; $display("FAIL simul_gap_cycles: got %0d want 4", nta); end
    if (n11 != 0)      begin n_fail++; $display("FAIL simul_both_drive: got %0d want 0", n11); end
    if (first10 != 21) begin n_fail++; $display("FAIL simul_port2_start: got %0d want 21", first10); end
  endtask

  task automatic test_withdraw();
    int nbeat = 0, nrx = 0, nta = 0, gap_beats = 0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      req_a = (c <= 4) ? 2'b10 : 2'b00; last_a = 2'b00;
      @(negedge clk);
      if (beat_a[1]) nbeat++;
      if (rx_a[0])   nrx++;
      if (ta_a) begin nta++; if (beat_a != 2'b00) gap_beats++; end
      if (c == 5) begin
        n_checks++;
        if (tx_a !== 2'b10) begin n_fail++; $display("FAIL withdraw_tx_c5: got %b want 10", tx_a); end
      end
      if (c == 6) begin
        n_checks++;
        if (tx_a !== 2'b00) begin n_fail++; $display("FAIL withdraw_tx_c6: got %b want 00", tx_a); end
      end
      advance();
    end
    n_checks += 4;
    if (nbeat != 3)     begin n_fail++; $display("FAIL withdraw_beats: got %0d want 3", nbeat); end
    if (nrx != 3)       begin n_fail++; $display("FAIL withdraw_rx: got %0d want 3", nrx); end
    if (nta != 2)       begin n_fail++; $display("FAIL withdraw_gap: got %0d want 2", nta); end
    if (gap_beats != 0) begin n_fail++; $display("FAIL withdraw_gap_beats: got %0d want 0", gap_beats); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      rst   = (c == 6);
      req_a = (c <= 6) ? 2'b01 : 2'b11; last_a = 2'b00;
      @(negedge clk);
      if (c == 6) begin
        n_checks++;
        if (beat_a !== 2'b01) begin n_fail++; $display("FAIL midrst_beat5: got %b want 01", beat_a); end
      end
      if (c == 7) begin
        n_checks += 2;
        if (tx_a !== 2'b00)  begin n_fail++; $display("FAIL midrst_tx: got %b want 00", tx_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy_a); end
      end
      if (c == 8) begin
        n_checks++;
        if (tx_a !== 2'b01) begin n_fail++; $display("FAIL midrst_regrant: got %b want 01", tx_a); end
      end
      advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_corners();
    logic [1:0] prev_grant = 2'b10;
    logic [1:0] prev_tx    = 2'b00;
    int ngrant = 0;
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      req_b = 2'b11; last_b = 2'b00;
      @(negedge clk);
      n_checks++;
      if (tx_b !== exp_tx(1)) begin n_fail++; $display("FAIL corner_model c%0d: got %b want %b", c, tx_b, exp_tx(1)); end
      if (tx_b != 2'b00) begin
        ngrant++;
        n_checks += 3;
        if (tx_b === prev_grant) begin n_fail++; $display("FAIL corner_alternate c%0d: got %b want not %b", c, tx_b, prev_grant); end
        if (prev_tx !== 2'b00)   begin n_fail++; $display("FAIL corner_single_cycle c%0d: got prev %b want 00", c, prev_tx); end
        if (beat_b !== tx_b)     begin n_fail++; $display("FAIL corner_one_beat c%0d: got %b want %b", c, beat_b, tx_b); end
        prev_grant = tx_b;
      end
      prev_tx = tx_b;
      advance();
    end
    n_checks++;
    if (ngrant != 8) begin n_fail++; $display("FAIL corner_grants: got %0d want 8", ngrant); end
  endtask

  task automatic test_random();
    logic [1:0] eb_a, eb_b;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst    = ($urandom_range(0, 127) == 0);
      req_a  = 2'($urandom_range(0, 3));
      req_b  = 2'($urandom_range(0, 3));
      last_a = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      last_b = 2'($urandom_range(0, 3));
      @(negedge clk);
      eb_a = exp_tx(0) & req_a;
      eb_b = exp_tx(1) & req_b;
      n_checks += 9;
      if (tx_a !== exp_tx(0))            begin n_fail++; $display("FAIL rand_tx_a c%0d: got %b want %b", c, tx_a, exp_tx(0)); end
      if (beat_a !== eb_a)               begin n_fail++; $display("FAIL rand_beat_a c%0d: got %b want %b", c, beat_a, eb_a); end
      if (rx_a !== {eb_a[0], eb_a[1]})   begin n_fail++; $display("FAIL rand_rx_a c%0d: got %b want %b", c, rx_a, {eb_a[0], eb_a[1]}); end
      if (ta_a !== exp_ta(0))            begin n_fail++; $display("FAIL rand_ta_a c%0d: got %b want %b", c, ta_a, exp_ta(0)); end
      if (busy_a !== exp_busy(0))        begin n_fail++; $display("FAIL rand_busy_a c%0d: got %b want %b", c, busy_a, exp_busy(0)); end
      if (tx_b !== exp_tx(1))            begin n_fail++; $display("FAIL rand_tx_b c%0d: got %b want %b", c, tx_b, exp_tx(1)); end
      if (beat_b !== eb_b)               begin n_fail++; $display("FAIL rand_beat_b c%0d: got %b want %b", c, beat_b, eb_b); end
      if (ta_b !== exp_ta(1))            begin n_fail++; $display("FAIL rand_ta_b c%0d: got %b want %b", c, ta_b, exp_ta(1)); end
      if (busy_b !== exp_busy(1))        begin n_fail++; $display("FAIL rand_busy_b c%0d: got %b want %b", c, busy_b, exp_busy(1)); end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_simultaneous();
    test_withdraw();
    test_reset_mid_burst();
    test_corners();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
